// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of an asynchronous 16-bit SRAM.
// Port 0 (video fetch) and port 1 (CPU) issue read/write commands.
// A granted command runs for ACCESS_CYCLES cycles with the chip enabled,
// then spends one RECOVER cycle with the chip disabled.
//
// Configuration macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   - simultaneous requests alternate through a round-robin pointer
//   undefined - fixed priority, port 0 always wins
//
// Ports:
//   clk_50_clk, reset_reset_n  clock, async active-low reset
//   pX_req/we/addr/wdata/be    command from port X (held until pX_gnt)
//   pX_gnt                     combinational one-cycle accept pulse (IDLE only)
//   pX_rvalid, rdata           read completion pulse and shared read data
//   sram_*                     registered SRAM pins (dq tri-state lives above)
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk_50_clk,
  input  logic        reset_reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [18:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [18:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] rdata,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [1:0]  sram_be_n
);

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [1:0]  be_n_q, be_n_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  rvalid_q, rvalid_d;

  logic        p0_sel, p1_sel;
  logic        sel_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // 0: port 0 wins the next tie, 1: port 1 wins the next tie
  logic rr_q, rr_d;
`endif

  // Grant selection; gated by reset so no grant leaks out while in reset.
  always_comb begin
    p0_sel = 1'b0;
    p1_sel = 1'b0;
    if (state_q == StIdle && reset_reset_n) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (p0_req && p1_req) begin
        p0_sel = ~rr_q;
        p1_sel = rr_q;
      end else begin
        p0_sel = p0_req;
        p1_sel = p1_req;
      end
`else
      p0_sel = p0_req;
      p1_sel = p1_req & ~p0_req;
`endif
    end
  end

  assign p0_gnt = p0_sel;
  assign p1_gnt = p1_sel;
  assign sel_we = p1_sel ? p1_we : p0_we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    be_n_d   = be_n_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (p0_sel || p1_sel) begin
          state_d  = StAccess;
          cnt_d    = 4'd0;
          port_d   = p1_sel;
          we_d     = sel_we;
          addr_d   = p1_sel ? p1_addr : p0_addr;
          dq_out_d = p1_sel ? p1_wdata : p0_wdata;
          be_n_d   = ~(p1_sel ? p1_be : p0_be);
          ce_n_d   = 1'b0;
          oe_n_d   = sel_we;
          // ACCESS_CYCLES >= 2, so the first cycle of a write always strobes
          we_n_d   = ~sel_we;
          dq_oe_d  = sel_we;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          rr_d     = p0_sel;
`endif
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StRecover;
          cnt_d   = 4'd0;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          be_n_d  = 2'b11;
          if (!we_q) begin
            rdata_d          = sram_dq_in;
            rvalid_d[port_q] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Release we_n for the final cycle so write data is held past it
          if (cnt_q + 4'd1 == LastCnt) begin
            we_n_d = 1'b1;
          end
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= 2'b11;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign p0_rvalid   = rvalid_q[0];
  assign p1_rvalid   = rvalid_q[1];
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed vectors, scoreboard of expected
// grant/rvalid events checked by an independent monitor process.
module tb_sram_arbiter;

  localparam int A = 2;

  logic        clk_50_clk;
  logic        reset_reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [18:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_be, p1_be;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] rdata, sram_dq_out, dq_in;
  logic [18:0] sram_addr;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;

  // Second instance with ACCESS_CYCLES=15, driven only through port 1
  logic        t_p1_req;
  logic        t_p0_gnt, t_p1_gnt, t_p0_rvalid, t_p1_rvalid;
  logic [15:0] t_rdata, t_dq_out;
  logic [18:0] t_addr;
  logic        t_dq_oe, t_ce_n, t_oe_n, t_we_n;
  logic [1:0]  t_be_n;

  sram_arbiter #(.ACCESS_CYCLES(A)) u_dut (
    .clk_50_clk(clk_50_clk), .reset_reset_n(reset_reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(dq_in), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  sram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
    .clk_50_clk(clk_50_clk), .reset_reset_n(reset_reset_n),
    .p0_req(1'b0), .p0_we(1'b0), .p0_addr(19'h0), .p0_wdata(16'h0), .p0_be(2'b00),
    .p0_gnt(t_p0_gnt), .p0_rvalid(t_p0_rvalid),
    .p1_req(t_p1_req), .p1_we(1'b0), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(2'b11),
    .p1_gnt(t_p1_gnt), .p1_rvalid(t_p1_rvalid),
    .rdata(t_rdata), .sram_addr(t_addr), .sram_dq_out(t_dq_out),
    .sram_dq_oe(t_dq_oe), .sram_dq_in(dq_in), .sram_ce_n(t_ce_n),
    .sram_oe_n(t_oe_n), .sram_we_n(t_we_n), .sram_be_n(t_be_n)
  );

  initial clk_50_clk = 1'b0;
  always #10 clk_50_clk = ~clk_50_clk;

  int cyc = 0;
  always @(posedge clk_50_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard of expected DUT events in order of occurrence
  typedef struct packed {
    logic        is_rv;
    logic        port;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic push_gnt(input logic p);
    exp_q.push_back('{is_rv: 1'b0, port: p, data: 16'h0});
  endtask

  task automatic push_rv(input logic p, input logic [15:0] d);
    exp_q.push_back('{is_rv: 1'b1, port: p, data: d});
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  int   gnt_cyc [2];
  logic [1:0] m_g, m_r;
  ev_t  m_e;
  always @(negedge clk_50_clk) begin
    m_g = {p1_gnt, p0_gnt};
    m_r = {p1_rvalid, p0_rvalid};
    if (m_g == 2'b11) fail_now("gnt_both_ports");
    for (int p = 0; p < 2; p++) begin
      if (m_g[p]) begin
        gnt_cyc[p] = cyc;
        if (exp_q.size() == 0) fail_now($sformatf("unexpected_gnt_p%0d", p));
        else begin
          m_e = exp_q.pop_front();
          chk($sformatf("sb_gnt_p%0d_event", p), {31'h0, m_e.is_rv, m_e.port},
              {31'h0, 1'b0, 1'(p)});
        end
      end
      if (m_r[p]) begin
        if (exp_q.size() == 0) fail_now($sformatf("unexpected_rvalid_p%0d", p));
        else begin
          m_e = exp_q.pop_front();
          chk($sformatf("sb_rv_p%0d_event", p), {31'h0, m_e.is_rv, m_e.port},
              {31'h0, 1'b1, 1'(p)});
          chk($sformatf("sb_rv_p%0d_rdata", p), rdata, m_e.data);
          chk($sformatf("sb_rv_p%0d_latency", p), cyc - gnt_cyc[p], A + 1);
        end
      end
    end
  end

  // Issue one command on a port; returns at posedge+1 of the first ACCESS cycle
  task automatic access(input logic port, input logic we, input logic [18:0] a,
                        input logic [15:0] wd, input logic [1:0] be);
    logic got;
    got = 1'b0;
    if (port) begin
      p1_we = we; p1_addr = a; p1_wdata = wd; p1_be = be; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = a; p0_wdata = wd; p0_be = be; p0_req = 1'b1;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_50_clk);
      got = port ? p1_gnt : p0_gnt;
    end
    if (!got) fail_now("gnt_timeout");
    @(posedge clk_50_clk);
    #1;
    if (port) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  // {ce_n, oe_n, we_n, dq_oe}
  task automatic chk_bus(input string name, input logic [3:0] req);
    chk(name, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, req);
  endtask

  int gc [4];
  int ng, cnt, n, rv_cyc, rel;
  logic got;
  logic [15:0] rv_data;

  initial begin
    reset_reset_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = 2'b11;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = 2'b11;
    t_p1_req = 1'b0;
    dq_in = 16'h0;

    // Reset state, with requests held high to prove no grant leaks
    repeat (3) @(negedge clk_50_clk);
    chk_bus("rst_strobes", 4'b1110);
    chk("rst_be_n", sram_be_n, 2'b11);
    chk("rst_addr", sram_addr, 19'h0);
    chk("rst_dq_out", sram_dq_out, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_gnt", {p1_gnt, p0_gnt}, 2'b00);
    chk("rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk_50_clk); #1;
    reset_reset_n = 1'b1;

    // Read on port 0
    dq_in = 16'hBEEF;
    push_gnt(1'b0); push_rv(1'b0, 16'hBEEF);
    access(1'b0, 1'b0, 19'h00010, 16'h0, 2'b11);
    @(negedge clk_50_clk);
    chk_bus("rd_acc1_bus", 4'b0010);
    chk("rd_acc1_addr", sram_addr, 19'h00010);
    chk("rd_acc1_be_n", sram_be_n, 2'b00);
    @(negedge clk_50_clk);
    chk_bus("rd_acc2_bus", 4'b0010);
    @(negedge clk_50_clk);
    chk_bus("rd_recover_bus", 4'b1110);
    chk("rd_recover_be_n", sram_be_n, 2'b11);
    @(posedge clk_50_clk); #1;

    // Write on port 1
    dq_in = 16'hDEAD;
    push_gnt(1'b1);
    access(1'b1, 1'b1, 19'h7FFFF, 16'h1234, 2'b10);
    @(negedge clk_50_clk);
    chk_bus("wr_acc1_bus", 4'b0101);
    chk("wr_be_n", sram_be_n, 2'b01);
    chk("wr_dq_out", sram_dq_out, 16'h1234);
    chk("wr_addr", sram_addr, 19'h7FFFF);
    @(negedge clk_50_clk);
    chk_bus("wr_acc2_bus", 4'b0111);
    @(negedge clk_50_clk);
    chk_bus("wr_recover_bus", 4'b1110);
    chk("wr_rdata_held", rdata, 16'hBEEF);
    @(posedge clk_50_clk); #1;

    // Contention: both ports hold read requests for four grants
    dq_in = 16'hA5A5;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      push_gnt(1'(k % 2)); push_rv(1'(k % 2), 16'hA5A5);
    end
`else
    for (int k = 0; k < 4; k++) begin
      push_gnt(1'b0); push_rv(1'b0, 16'hA5A5);
    end
`endif
    p0_we = 1'b0; p0_addr = 19'h00100; p1_we = 1'b0; p1_addr = 19'h00200;
    p0_req = 1'b1; p1_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk_50_clk);
      if (p0_gnt || p1_gnt) begin
        gc[ng] = cyc;
        ng++;
      end
    end
    chk("cont_grant_count", ng, 4);
    @(posedge clk_50_clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    for (int k = 1; k < 4; k++) chk($sformatf("cont_spacing_%0d", k), gc[k] - gc[k-1], A + 2);
    repeat (A + 3) @(posedge clk_50_clk);
    #1;

    // Dropped request: p1 pulses for one cycle during a busy p0 read
    dq_in = 16'h5A5A;
    push_gnt(1'b0); push_rv(1'b0, 16'h5A5A);
    access(1'b0, 1'b0, 19'h0ABCD, 16'h0, 2'b11);
    p1_we = 1'b1; p1_addr = 19'h11111; p1_wdata = 16'h7777; p1_req = 1'b1;
    @(posedge clk_50_clk); #1;
    p1_req = 1'b0;
    @(negedge clk_50_clk);
    chk("drop_busy_addr", sram_addr, 19'h0ABCD);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50_clk);
      if (!sram_ce_n) cnt++;
    end
    chk("drop_no_p1_ce", cnt, 0);
    chk("drop_final_addr", sram_addr, 19'h0ABCD);
    @(posedge clk_50_clk); #1;

    // Reset in the second ACCESS cycle of a read
    dq_in = 16'h1111;
    push_gnt(1'b0);
    access(1'b0, 1'b0, 19'h00321, 16'h0, 2'b11);
    @(posedge clk_50_clk); #2;
    reset_reset_n = 1'b0;
    #1;
    chk_bus("rstmid_strobes", 4'b1110);
    chk("rstmid_be_n", sram_be_n, 2'b11);
    dq_in = 16'h2222;
    p1_we = 1'b0; p1_addr = 19'h00444; p1_req = 1'b1;
    @(negedge clk_50_clk);
    chk("rstmid_gnt_gated", p1_gnt, 1'b0);
    push_gnt(1'b1); push_rv(1'b1, 16'h2222);
    @(posedge clk_50_clk); #1;
    reset_reset_n = 1'b1;
    rel = cyc;
    @(negedge clk_50_clk);
    chk("rstmid_first_gnt", p1_gnt, 1'b1);
    chk("rstmid_gnt_cycle", cyc - rel, 0);
    @(posedge clk_50_clk); #1;
    p1_req = 1'b0;
    repeat (A + 3) @(posedge clk_50_clk);
    #1;

    // ACCESS_CYCLES=15 instance: port 1 read
    dq_in = 16'hC0DE;
    t_p1_req = 1'b1;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_50_clk);
      got = t_p1_gnt;
      n = cyc;
    end
    chk("a15_gnt_seen", got, 1'b1);
    @(posedge clk_50_clk); #1;
    t_p1_req = 1'b0;
    cnt = 0;
    rv_cyc = -1;
    rv_data = 16'h0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50_clk);
      if (!t_ce_n) cnt++;
      if (t_p1_rvalid) begin
        rv_cyc = cyc;
        rv_data = t_rdata;
      end
    end
    chk("a15_ce_cycles", cnt, 15);
    chk("a15_rvalid_cycle", rv_cyc - n, 16);
    chk("a15_rdata", rv_data, 16'hC0DE);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
